writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Writeback stage directly upstream of register_file: merges the ALU result path and the
//  variable-latency load-return path into the single register-file write port.
//  ALU writes win by default. Load returns are buffered in a small FIFO.
//  A starvation limit guarantees loads drain. Hazard flags let decode stall on pending loads.
// PARAMETERS
//  DATA_W      16  width of write data (matches register_file)
//  FIFO_DEPTH  4   load-return buffer entries (power of 2, >=2)
//  STARVE_MAX  3   consecutive ALU wins with a non-empty FIFO before the ALU is stalled
// PORTS
//  clk          in   1       system clock
//  arst_n       in   1       asynchronous reset, active low
//  alu_valid    in   1       ALU result present this cycle
//  alu_stall    out  1       ALU result NOT accepted this cycle; upstream holds it
//  alu_waddr    in   5       ALU destination register
//  alu_wdata    in   DATA_W  ALU result
//  ld_valid     in   1       load return present
//  ld_ready     out  1       load return accepted when ld_valid&&ld_ready
//  ld_waddr     in   5       load destination register
//  ld_wdata     in   DATA_W  load data
//  reg_write    out  1       register_file write enable (registered)
//  waddr        out  5       register_file write address (registered)
//  wdata        out  DATA_W  register_file write data (registered)
//  qaddr_1      in   5       decode source-1 query address
//  qaddr_2      in   5       decode source-2 query address
//  qaddr_d      in   5       decode destination query address
//  hazard_1     out  1       qaddr_1 matches a valid FIFO entry
//  hazard_2     out  1       qaddr_2 matches a valid FIFO entry
//  hazard_d     out  1       qaddr_d matches a valid FIFO entry
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  occupied entries
// BEHAVIOUR
//  - Reset (arst_n=0, async): reg_write=0, waddr=0, wdata=0, FIFO empty, fifo_count=0,
//    starve counter=0. Combinational outputs follow from this state: ld_ready=1, alu_stall=0,
//    hazards=0. Reset mid-operation discards all queued loads.
//  - ld_ready = (fifo_count < FIFO_DEPTH), from registered count only (no ld_valid path).
//    When full, ld_ready=0 even if a pop happens in the same cycle.
//  - alu_stall = (starve_cnt == STARVE_MAX) && (fifo_count != 0).
//  - Per-cycle grant, priority order, result registered onto reg_write/waddr/wdata next edge:
//    1. alu_valid && !alu_stall       -> ALU write; starve_cnt++ if FIFO non-empty, else 0.
//    2. else if FIFO non-empty         -> pop head to output; starve_cnt=0.
//    3. else if ld_valid (FIFO empty)  -> bypass: load goes to output, not enqueued.
//    4. else reg_write<=0 (waddr/wdata hold last value).
//  - Accepted load not consumed by bypass is pushed at the tail. Push and pop may occur
//    in the same cycle; count is unchanged.
//  - Latency: ALU or bypassed load appears on the write port 1 cycle after acceptance.
//    Queued loads drain in FIFO order.
//  - Order: loads retire in arrival order. ALU/load ordering to the same register is guaranteed
//    by decode stalling on hazard_* (no WAR/WAW across paths is handled here).
//  - Hazards are combinational compares of qaddr_* against valid FIFO entries only.
//    Bypassed and in-flight-to-output writes are not flagged: register_file writes at the next
//    edge, so those are covered by the 1-cycle write timing.
//  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. fifo_count saturates by
//    construction: push is blocked when full, pop is blocked when empty.
// STRUCTURE
//  - Shared package cpu_pkg: REG_ADDR_W=5, DATA_W=16, N_REG=32.
//  - Sub-module wb_fifo holds storage, pointers and count, with a per-entry valid/addr view
//    exposed for hazard compares.
//  - Top level holds grant logic, the starve counter and the output registers.
// TESTING
//  - Reset: hold arst_n=0 with random inputs -> reg_write=0, ld_ready=1, fifo_count=0, hazards 0.
//  - Bypass: idle; ld_valid, ld_waddr=5, ld_wdata=16'hBEEF -> next cycle reg_write=1, waddr=5,
//    wdata=16'hBEEF; fifo_count stays 0.
//  - Conflict: alu_valid(r3=16'h0011) and ld(r7=16'h0022) in the same cycle -> r3 written at +1,
//    r7 written at +2; hazard_1 is 1 at +1 when qaddr_1=7.
//  - Full: alu_valid held high, 4 loads pushed -> ld_ready=0, 5th load held off.
//    Entries retire in push order, no loss.
//  - Starvation: FIFO non-empty, alu_valid continuous -> alu_stall=1 on the 4th cycle.
//    One load pops, then ALU resumes; the stalled ALU value is written exactly once.
//  - Async reset with 3 entries queued -> outputs 0 immediately, and no queued load is written
//    after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and writeback grant encoding.
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 16;
    localparam int N_REG      = 32;

    // Which source owns the register-file write port this cycle
    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_ALU    = 2'd1,
        GNT_FIFO   = 2'd2,
        GNT_BYPASS = 2'd3
    } grant_e;
endpackage

// File: rtl/wb_fifo.sv
// Load-return buffer for the writeback stage. Exposes a per-entry valid/addr
// view so decode can detect reads/writes of registers with loads still queued.
module wb_fifo #(
    parameter  int DATA_W = cpu_pkg::DATA_W,
    parameter  int DEPTH  = 4,
    localparam int AW     = cpu_pkg::REG_ADDR_W,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        push,
    input  logic [AW-1:0]               push_addr,
    input  logic [DATA_W-1:0]           push_data,
    input  logic                        pop,
    output logic [AW-1:0]               head_addr,
    output logic [DATA_W-1:0]           head_data,
    output logic [CNT_W-1:0]            count,
    output logic [DEPTH-1:0]            entry_vld,
    output logic [DEPTH-1:0][AW-1:0]    entry_addr
);
    logic [DEPTH-1:0][AW-1:0]     mem_addr;
    logic [DEPTH-1:0][DATA_W-1:0] mem_data;
    logic [PTR_W-1:0]             wr_ptr;
    logic [PTR_W-1:0]             rd_ptr;
    logic                         push_ok;
    logic                         pop_ok;

    // Guard here too so the count can never over/underflow whatever the caller does
    assign push_ok = push && (count != CNT_W'(DEPTH));
    assign pop_ok  = pop  && (count != '0);

    assign head_addr  = mem_addr[rd_ptr];
    assign head_data  = mem_data[rd_ptr];
    assign entry_addr = mem_addr;

    // Storage needs no reset: validity comes from the pointers and count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally; count moves only on an unpaired push or pop
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // An entry is live if its distance from the head is below the occupancy
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs      = '0;
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs         = PTR_W'(i) - rd_ptr;
            entry_vld[i] = ({1'b0, offs} < count);
        end
    end
endmodule

// File: rtl/writeback_arbiter.sv
// Writeback stage: merges ALU results and load returns onto the single
// register-file write port. ALU wins by default; loads queue in wb_fifo and a
// starvation counter forces a drain after STARVE_MAX consecutive ALU wins.
module writeback_arbiter #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          alu_valid,
    output logic                          alu_stall,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] alu_waddr,
    input  logic [DATA_W-1:0]             alu_wdata,
    input  logic                          ld_valid,
    output logic                          ld_ready,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0]             ld_wdata,
    output logic                          reg_write,
    output logic [cpu_pkg::REG_ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0]             wdata,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] qaddr_1,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] qaddr_2,
    input  logic [cpu_pkg::REG_ADDR_W-1:0] qaddr_d,
    output logic                          hazard_1,
    output logic                          hazard_2,
    output logic                          hazard_d,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import cpu_pkg::*;

    localparam int AW       = REG_ADDR_W;
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    grant_e                      grant;
    logic [STARVE_W-1:0]         starve_cnt;
    logic                        fifo_empty;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic [AW-1:0]               head_addr;
    logic [DATA_W-1:0]           head_data;
    logic [CNT_W-1:0]            count;
    logic [FIFO_DEPTH-1:0]       entry_vld;
    logic [FIFO_DEPTH-1:0][AW-1:0] entry_addr;

    wb_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .arst_n     (arst_n),
        .push       (fifo_push),
        .push_addr  (ld_waddr),
        .push_data  (ld_wdata),
        .pop        (fifo_pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .entry_vld  (entry_vld),
        .entry_addr (entry_addr)
    );

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    // Registered count only, so ld_ready has no combinational path from ld_valid
    assign ld_ready   = (count != CNT_W'(FIFO_DEPTH));
    assign alu_stall  = (starve_cnt == STARVE_W'(STARVE_MAX)) && !fifo_empty;

    // Fixed-priority grant: ALU, then queued load, then load bypass on empty FIFO
    always_comb begin
        grant = GNT_NONE;
        if (alu_valid && !alu_stall) grant = GNT_ALU;
        else if (!fifo_empty)        grant = GNT_FIFO;
        else if (ld_valid)           grant = GNT_BYPASS;
    end

    assign fifo_pop  = (grant == GNT_FIFO);
    assign fifo_push = ld_valid && ld_ready && (grant != GNT_BYPASS);

    // Count ALU wins that overtake queued loads; any other grant clears it
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)               starve_cnt <= '0;
        else if (grant == GNT_ALU) starve_cnt <= fifo_empty ? '0 : starve_cnt + 1'b1;
        else                       starve_cnt <= '0;
    end

    // Register the granted write; address/data hold when nothing is written
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            reg_write <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            case (grant)
                GNT_ALU: begin
                    reg_write <= 1'b1;
                    waddr     <= alu_waddr;
                    wdata     <= alu_wdata;
                end
                GNT_FIFO: begin
                    reg_write <= 1'b1;
                    waddr     <= head_addr;
                    wdata     <= head_data;
                end
                GNT_BYPASS: begin
                    reg_write <= 1'b1;
                    waddr     <= ld_waddr;
                    wdata     <= ld_wdata;
                end
                default: reg_write <= 1'b0;
            endcase
        end
    end

    // Flag queued loads only; writes already headed to the port land next edge
    always_comb begin
        hazard_1 = 1'b0;
        hazard_2 = 1'b0;
        hazard_d = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_vld[i] && entry_addr[i] == qaddr_1) hazard_1 = 1'b1;
            if (entry_vld[i] && entry_addr[i] == qaddr_2) hazard_2 = 1'b1;
            if (entry_vld[i] && entry_addr[i] == qaddr_d) hazard_d = 1'b1;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based model of the arbiter.
module tb_writeback_arbiter;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SMAX  = 3;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          alu_valid, alu_stall;
    logic [4:0]    alu_waddr;
    logic [DW-1:0] alu_wdata;
    logic          ld_valid, ld_ready;
    logic [4:0]    ld_waddr;
    logic [DW-1:0] ld_wdata;
    logic          reg_write;
    logic [4:0]    waddr;
    logic [DW-1:0] wdata;
    logic [4:0]    qaddr_1, qaddr_2, qaddr_d;
    logic          hazard_1, hazard_2, hazard_d;
    logic [2:0]    fifo_count;

    always #5 clk = ~clk;

    writeback_arbiter #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .arst_n(arst_n),
        .alu_valid(alu_valid), .alu_stall(alu_stall), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
        .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
        .qaddr_1(qaddr_1), .qaddr_2(qaddr_2), .qaddr_d(qaddr_d),
        .hazard_1(hazard_1), .hazard_2(hazard_2), .hazard_d(hazard_d),
        .fifo_count(fifo_count)
    );

    typedef struct packed { logic [4:0] a; logic [DW-1:0] d; } ent_t;

    // Model state: queued loads in arrival order, starvation run, expected port
    ent_t          mq[$];
    int            starve;
    logic          e_rw;
    logic [4:0]    e_wa;
    logic [DW-1:0] e_wd;
    bit            acc_alu, acc_ld;
    bit            en_seen;
    logic [DW-1:0] seen[$];
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic bit hits(input logic [4:0] q);
        foreach (mq[i]) if (mq[i].a == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mrst();
        mq.delete();
        starve = 0;
        e_rw = 1'b0; e_wa = '0; e_wd = '0;
    endtask

    task automatic idle();
        alu_valid = 1'b0; ld_valid = 1'b0;
        qaddr_1 = '0; qaddr_2 = '0; qaddr_d = '0;
    endtask

    // One clock: check combinational outputs, advance the model, check the port.
    // Entered and left just after a falling edge with inputs already driven.
    task automatic cyc();
        int   n;
        bit   stall, byp;
        ent_t e;
        #1;
        n     = mq.size();
        stall = (starve == SMAX) && (n != 0);
        chk("ld_ready",   ld_ready,   n < DEPTH);
        chk("alu_stall",  alu_stall,  stall);
        chk("fifo_count", fifo_count, n);
        chk("hazard_1",   hazard_1,   hits(qaddr_1));
        chk("hazard_2",   hazard_2,   hits(qaddr_2));
        chk("hazard_d",   hazard_d,   hits(qaddr_d));
        acc_alu = 1'b0;
        byp     = 1'b0;
        if (alu_valid && !stall) begin
            e_rw = 1'b1; e_wa = alu_waddr; e_wd = alu_wdata;
            starve  = (n != 0) ? starve + 1 : 0;
            acc_alu = 1'b1;
        end else if (n != 0) begin
            e = mq.pop_front();
            e_rw = 1'b1; e_wa = e.a; e_wd = e.d;
            starve = 0;
        end else if (ld_valid) begin
            e_rw = 1'b1; e_wa = ld_waddr; e_wd = ld_wdata;
            byp = 1'b1;
        end else begin
            e_rw = 1'b0;
        end
        acc_ld = ld_valid && (n < DEPTH);
        if (acc_ld && !byp) mq.push_back({ld_waddr, ld_wdata});
        @(posedge clk);
        #1;
        chk("reg_write", reg_write, e_rw);
        chk("waddr",     waddr,     e_wa);
        chk("wdata",     wdata,     e_wd);
        if (en_seen && reg_write && wdata[15:12] == 4'hC) seen.push_back(wdata);
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] hv;
        logic [DW-1:0] av;
        int            nld;
        mrst();
        en_seen = 1'b0;
        arst_n  = 1'b0;
        idle();
        alu_waddr = '0; alu_wdata = '0; ld_waddr = '0; ld_wdata = '0;

        // Reset held with random inputs
        repeat (4) begin
            @(negedge clk);
            alu_valid = 1'($urandom); ld_valid = 1'($urandom);
            alu_waddr = 5'($urandom); alu_wdata = 16'($urandom);
            ld_waddr  = 5'($urandom); ld_wdata  = 16'($urandom);
            qaddr_1 = 5'($urandom); qaddr_2 = 5'($urandom); qaddr_d = 5'($urandom);
            #1;
            chk("rst_rw",    reg_write, 0);
            chk("rst_wa",    waddr,     0);
            chk("rst_rdy",   ld_ready,  1);
            chk("rst_cnt",   fifo_count, 0);
            chk("rst_stall", alu_stall, 0);
            chk("rst_haz",   {hazard_1, hazard_2, hazard_d}, 0);
        end
        @(negedge clk);
        idle();
        arst_n = 1'b1;

        // Bypass on an empty FIFO
        ld_valid = 1'b1; ld_waddr = 5'd5; ld_wdata = 16'hBEEF;
        cyc();
        chk("byp_rw",  reg_write, 1);
        chk("byp_wa",  waddr, 5);
        chk("byp_wd",  wdata, 16'hBEEF);
        chk("byp_cnt", fifo_count, 0);
        idle();
        cyc();

        // ALU and load in the same cycle
        alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 16'h0011;
        ld_valid  = 1'b1; ld_waddr  = 5'd7; ld_wdata  = 16'h0022;
        cyc();
        chk("conf_wa1", waddr, 3);
        chk("conf_wd1", wdata, 16'h0011);
        idle();
        qaddr_1 = 5'd7;
        #1;
        chk("conf_haz", hazard_1, 1);
        cyc();
        chk("conf_wa2", waddr, 7);
        chk("conf_wd2", wdata, 16'h0022);
        idle();
        cyc();

        // Fill with ALU held high, then drain; loads must retire in push order
        en_seen = 1'b1;
        seen.delete();
        alu_valid = 1'b1; alu_waddr = 5'd1;
        av = 16'hA000;
        for (int k = 0; k < 4; k++) begin
            alu_wdata = av;
            ld_valid = 1'b1; ld_waddr = 5'(10 + k); ld_wdata = 16'(16'hC000 + k);
            cyc();
            if (acc_alu) av = av + 1'b1;
        end
        chk("full_rdy", ld_ready, 0);
        chk("full_cnt", fifo_count, 4);
        ld_waddr = 5'd14; ld_wdata = 16'hC004;
        alu_wdata = av;
        nld = 4;
        repeat (24) begin
            cyc();
            if (acc_alu) begin av = av + 1'b1; alu_wdata = av; end
            if (acc_ld) ld_valid = 1'b0;
        end
        idle();
        repeat (4) cyc();
        en_seen = 1'b0;
        chk("full_nret", seen.size(), 5);
        foreach (seen[i]) chk("full_order", seen[i], 16'(16'hC000 + i));
        nld = nld + 1;

        // Starvation: one queued load, continuous ALU
        alu_valid = 1'b1; alu_waddr = 5'd2; alu_wdata = 16'h7000;
        ld_valid  = 1'b1; ld_waddr  = 5'd9; ld_wdata  = 16'h5555;
        cyc();
        ld_valid = 1'b0;
        alu_wdata = 16'h7001;
        hv = '0;
        for (int i = 1; i <= 6; i++) begin
            #1;
            chk("starve_stall", alu_stall, i == 4);
            if (i == 4) hv = alu_wdata;
            cyc();
            if (i == 4) chk("starve_pop", wdata, 16'h5555);
            if (i == 5) chk("starve_resume", wdata, hv);
            if (i == 6) chk("starve_once", wdata, hv + 16'd1);
            if (acc_alu) alu_wdata = alu_wdata + 1'b1;
        end
        idle();
        cyc();

        // Async reset with three loads queued
        alu_valid = 1'b1; alu_waddr = 5'd4;
        for (int k = 0; k < 3; k++) begin
            alu_wdata = 16'(16'h3000 + k);
            ld_valid = 1'b1; ld_waddr = 5'd20; ld_wdata = 16'(16'h9000 + k);
            cyc();
        end
        chk("ar_pre", fifo_count, 3);
        idle();
        qaddr_1 = 5'd20;
        #2;
        arst_n = 1'b0;
        #1;
        chk("ar_rw",  reg_write, 0);
        chk("ar_wa",  waddr, 0);
        chk("ar_wd",  wdata, 0);
        chk("ar_cnt", fifo_count, 0);
        chk("ar_rdy", ld_ready, 1);
        chk("ar_haz", hazard_1, 0);
        mrst();
        @(negedge clk);
        arst_n = 1'b1;
        repeat (6) cyc();

        // Randomized traffic; stalled ALU and refused loads are held by the source
        alu_waddr = '0; alu_wdata = '0; ld_waddr = '0; ld_wdata = '0;
        repeat (400) begin
            if (!alu_valid || acc_alu) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_waddr = 5'($urandom_range(0, 7));
                alu_wdata = 16'($urandom);
            end
            if (!ld_valid || acc_ld) begin
                ld_valid = ($urandom_range(0, 99) < 50);
                ld_waddr = 5'($urandom_range(0, 7));
                ld_wdata = 16'($urandom);
            end
            qaddr_1 = 5'($urandom_range(0, 7));
            qaddr_2 = 5'($urandom_range(0, 7));
            qaddr_d = 5'($urandom_range(0, 7));
            acc_alu = 1'b0;
            acc_ld  = 1'b0;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
